regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file with an integrated busy-bit scoreboard, successor to the single-write, two-read register file.
- Sits in the decode/writeback boundary of the CPU datapath.
- Provides NREAD combinational read ports and two write ports (ALU and load writeback).
- Provides optional write-to-read bypass and a per-register busy scoreboard for hazard detection.

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; DEPTH = 2**AW registers.
- NREAD, 2, number of read ports (1..4).
- ZERO_R0, 1, 1 = register 0 hardwired to zero, never written, never busy.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- regwr0  in  1  write enable, port 0.
- wreg0  in  AW  write address, port 0.
- wdata0  in  DW  write data, port 0.
- regwr1  in  1  write enable, port 1 (priority port).
- wreg1  in  AW  write address, port 1.
- wdata1  in  DW  write data, port 1.
- rreg  in  NREAD*AW  packed read addresses; port i = bits [i*AW +: AW].
- rdata  out  NREAD*DW  packed read data, port i = bits [i*DW +: DW].
- rbusy  out  NREAD  busy flag per read port.
- mark_en  in  1  issue: mark mark_reg busy.
- mark_reg  in  AW  register to mark busy.
- busy_cnt  out  AW+1  number of registers currently busy.

Behaviour:
- Reset (rst=0, asynchronous): all DEPTH registers = 0, all busy bits = 0, busy_cnt = 0. Consequently rdata = 0 and rbusy = 0 for all ports while in reset. Release is sampled on the next rising clk; no state changes while rst=0 regardless of enables.
- Write: on rising clk, if regwrN=1, reg[wregN] <= wdataN. Both ports same address in same cycle: port 1 wins, port 0 dropped.
- ZERO_R0=1: writes to address 0 ignored; address 0 reads 0 and rbusy=0.
- Read: combinational, zero latency.
  - BYPASS=0: rdata_i = reg[rreg_i] (pre-edge value).
  - BYPASS=1: if regwr1 & wreg1==rreg_i then wdata1; else if regwr0 & wreg0==rreg_i then wdata0; else reg[rreg_i]. Bypass never applies to address 0 when ZERO_R0=1.
- Scoreboard, per register busy bit:
  - set on rising clk when mark_en=1 for mark_reg;
  - cleared on rising clk when written by either port;
  - same register set and cleared same edge: set wins (new producer);
  - mark of an already-busy register: stays busy, no count change;
  - write to a non-busy register: no count change.
- busy_cnt: registered; equals popcount of busy bits after every edge. Net change per edge is -2..+1. Must never underflow or exceed DEPTH (or DEPTH-1 with ZERO_R0).
- rbusy_i = busy[rreg_i], except when BYPASS=1 and a write this cycle targets rreg_i, then rbusy_i = 0 (data forwarded).
- No X propagation: unused read addresses still return defined storage values.

Test Plan:
- Reset then idle → every rreg returns rdata=0, rbusy=0, busy_cnt=0. Assert rst=0 mid-run after writes → rdata=0 immediately, without waiting for clk.
- Write reg20=0x0000000F (port 0), then reg3=0x000F0000 (port 1) on the next edge; read rreg={3,20} → rdata0=0x0000000F, rdata1=0x000F0000.
- Same-edge collision: regwr0 reg5=0x11111111 and regwr1 reg5=0x22222222 → reg5 reads 0x22222222. Write reg0=0xFFFFFFFF → reg0 reads 0.
- Bypass with BYPASS=1: reg7 holds 0xA; same cycle regwr0 reg7=0xB, read reg7 → rdata=0xB before the edge. Repeat with BYPASS=0 → 0xA before the edge, 0xB after.
- Scoreboard counts:
  - mark reg9, reg10, reg0 on three edges → busy_cnt=2; rbusy high for 9 and 10, low for 0;
  - write reg9 → busy_cnt=1;
  - same edge mark reg10 and write reg10 → reg10 stays busy, busy_cnt=1.
- Double-clear edge: reg4 and reg6 busy (busy_cnt=2); write both via ports 0/1 on one edge → busy_cnt=0. Same edge with mark reg8 → busy_cnt=1.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, optional
// write-to-read bypass and a per-register busy scoreboard.
module regfile_mp #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int NREAD   = 2,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                regwr0,
  input  logic [AW-1:0]       wreg0,
  input  logic [DW-1:0]       wdata0,
  input  logic                regwr1,
  input  logic [AW-1:0]       wreg1,
  input  logic [DW-1:0]       wdata1,
  input  logic [NREAD*AW-1:0] rreg,
  output logic [NREAD*DW-1:0] rdata,
  output logic [NREAD-1:0]    rbusy,
  input  logic                mark_en,
  input  logic [AW-1:0]       mark_reg,
  output logic [AW:0]         busy_cnt
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    regs_q [DEPTH];
  logic [DW-1:0]    regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_d;

  // Next storage: port 1 has priority on a same-address collision.
  always_comb begin
    regs_d = regs_q;
    for (int r = 0; r < DEPTH; r++) begin
      if (!(ZERO_R0 != 0 && r == 0)) begin
        if (regwr1 && wreg1 == AW'(r))
          regs_d[r] = wdata1;
        else if (regwr0 && wreg0 == AW'(r))
          regs_d[r] = wdata0;
      end
    end
  end

  // Next busy vector (a new mark beats a clearing write) and its popcount.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = '0;
    for (int r = 0; r < DEPTH; r++) begin
      if (ZERO_R0 != 0 && r == 0) begin
        busy_d[r] = 1'b0;
      end else begin
        busy_d[r] = (mark_en && mark_reg == AW'(r)) |
                    (busy_q[r] &
                     ~((regwr0 && wreg0 == AW'(r)) |
                       (regwr1 && wreg1 == AW'(r))));
      end
      cnt_d = cnt_d + (AW+1)'(busy_d[r]);
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++)
        regs_q[r] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++)
        regs_q[r] <= regs_d[r];
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  // Combinational read ports with optional forwarding of this cycle's writes.
  always_comb begin
    logic [AW-1:0] a;
    logic [DW-1:0] rd;
    logic          z;
    logic          h0;
    logic          h1;
    rdata = '0;
    rbusy = '0;
    for (int i = 0; i < NREAD; i++) begin
      a  = rreg[i*AW +: AW];
      z  = (ZERO_R0 != 0) && (a == '0);
      h1 = (BYPASS != 0) && regwr1 && (wreg1 == a) && !z;
      h0 = (BYPASS != 0) && regwr0 && (wreg0 == a) && !z;
      rd = regs_q[a];
      if (h1)
        rd = wdata1;
      else if (h0)
        rd = wdata0;
      if (rst) begin
        rdata[i*DW +: DW] = rd;
        rbusy[i]          = busy_q[a] & ~(h0 | h1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp; runs a bypassing
// and a non-bypassing instance side by side on shared inputs.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        regwr0, regwr1, mark_en;
  logic [4:0]  wreg0, wreg1, mark_reg;
  logic [31:0] wdata0, wdata1;
  logic [9:0]  rreg;
  logic [63:0] rdata_b, rdata_n;
  logic [1:0]  rbusy_b, rbusy_n;
  logic [5:0]  cnt_b, cnt_n;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) dut_b (
    .clk(clk), .rst(rst),
    .regwr0(regwr0), .wreg0(wreg0), .wdata0(wdata0),
    .regwr1(regwr1), .wreg1(wreg1), .wdata1(wdata1),
    .rreg(rreg), .rdata(rdata_b), .rbusy(rbusy_b),
    .mark_en(mark_en), .mark_reg(mark_reg), .busy_cnt(cnt_b)
  );

  regfile_mp #(.BYPASS(0)) dut_n (
    .clk(clk), .rst(rst),
    .regwr0(regwr0), .wreg0(wreg0), .wdata0(wdata0),
    .regwr1(regwr1), .wreg1(wreg1), .wdata1(wdata1),
    .rreg(rreg), .rdata(rdata_n), .rbusy(rbusy_n),
    .mark_en(mark_en), .mark_reg(mark_reg), .busy_cnt(cnt_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    regwr0 = 0; regwr1 = 0; mark_en = 0;
    wreg0 = 0; wreg1 = 0; mark_reg = 0;
    wdata0 = 0; wdata1 = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i += 5) begin
      rreg = {5'(31 - i), 5'(i)};
      #1;
      checks++;
      if (rdata_b !== 64'h0 || rbusy_b !== 2'b00 || cnt_b !== 6'd0) begin
        failures++;
        $display("FAIL reset_idle a=%0d rdata=%h rbusy=%b cnt=%0d exp 0/0/0",
                 i, rdata_b, rbusy_b, cnt_b);
      end
    end
    // Enables high while in reset must not change state.
    regwr0 = 1; wreg0 = 5'd1; wdata0 = 32'h55;
    mark_en = 1; mark_reg = 5'd2;
    tick();
    idle();
    rst = 1;
    tick();
    rreg = {5'd2, 5'd1};
    #1;
    checks++;
    if (rdata_b !== 64'h0 || rbusy_b !== 2'b00 || cnt_b !== 6'd0) begin
      failures++;
      $display("FAIL reset_hold rdata=%h rbusy=%b cnt=%0d exp 0/0/0",
               rdata_b, rbusy_b, cnt_b);
    end
  endtask

  task automatic test_write();
    regwr0 = 1; wreg0 = 5'd20; wdata0 = 32'h0000000F;
    tick();
    idle();
    regwr1 = 1; wreg1 = 5'd3; wdata1 = 32'h000F0000;
    tick();
    idle();
    rreg = {5'd3, 5'd20};
    #1;
    checks++;
    if (rdata_b !== {32'h000F0000, 32'h0000000F}) begin
      failures++;
      $display("FAIL write_read_b got=%h exp=%h", rdata_b,
               {32'h000F0000, 32'h0000000F});
    end
    checks++;
    if (rdata_n !== {32'h000F0000, 32'h0000000F}) begin
      failures++;
      $display("FAIL write_read_n got=%h exp=%h", rdata_n,
               {32'h000F0000, 32'h0000000F});
    end
  endtask

  task automatic test_collision();
    regwr0 = 1; wreg0 = 5'd5; wdata0 = 32'h11111111;
    regwr1 = 1; wreg1 = 5'd5; wdata1 = 32'h22222222;
    tick();
    idle();
    rreg = {5'd0, 5'd5};
    #1;
    checks++;
    if (rdata_n[31:0] !== 32'h22222222) begin
      failures++;
      $display("FAIL collision got=%h exp=22222222", rdata_n[31:0]);
    end
    regwr0 = 1; wreg0 = 5'd0; wdata0 = 32'hFFFFFFFF;
    rreg = {5'd0, 5'd0};
    #1;
    checks++;
    if (rdata_b !== 64'h0) begin
      failures++;
      $display("FAIL r0_no_bypass got=%h exp=0", rdata_b);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rdata_b !== 64'h0 || rdata_n !== 64'h0) begin
      failures++;
      $display("FAIL r0_write got=%h/%h exp=0", rdata_b, rdata_n);
    end
  endtask

  task automatic test_bypass();
    regwr1 = 1; wreg1 = 5'd7; wdata1 = 32'hA;
    tick();
    idle();
    regwr0 = 1; wreg0 = 5'd7; wdata0 = 32'hB;
    rreg = {5'd20, 5'd7};
    #1;
    checks++;
    if (rdata_b[31:0] !== 32'hB) begin
      failures++;
      $display("FAIL bypass_on got=%h exp=b", rdata_b[31:0]);
    end
    checks++;
    if (rdata_n[31:0] !== 32'hA) begin
      failures++;
      $display("FAIL bypass_off_pre got=%h exp=a", rdata_n[31:0]);
    end
    checks++;
    if (rdata_b[63:32] !== 32'hF) begin
      failures++;
      $display("FAIL bypass_other_port got=%h exp=f", rdata_b[63:32]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rdata_n[31:0] !== 32'hB || rdata_b[31:0] !== 32'hB) begin
      failures++;
      $display("FAIL bypass_post got=%h/%h exp=b", rdata_n[31:0], rdata_b[31:0]);
    end
  endtask

  task automatic test_scoreboard();
    mark_en = 1; mark_reg = 5'd9;  tick();
    mark_reg = 5'd10; tick();
    mark_reg = 5'd0;  tick();
    idle();
    checks++;
    if (cnt_b !== 6'd2 || cnt_n !== 6'd2) begin
      failures++;
      $display("FAIL mark_cnt got=%0d/%0d exp=2", cnt_b, cnt_n);
    end
    rreg = {5'd10, 5'd9};
    #1;
    checks++;
    if (rbusy_b !== 2'b11) begin
      failures++;
      $display("FAIL rbusy_9_10 got=%b exp=11", rbusy_b);
    end
    rreg = {5'd0, 5'd0};
    #1;
    checks++;
    if (rbusy_b !== 2'b00) begin
      failures++;
      $display("FAIL rbusy_r0 got=%b exp=00", rbusy_b);
    end
    regwr0 = 1; wreg0 = 5'd9; wdata0 = 32'h99;
    rreg = {5'd10, 5'd9};
    #1;
    checks++;
    if (rbusy_b !== 2'b10 || rbusy_n !== 2'b11) begin
      failures++;
      $display("FAIL rbusy_fwd got=%b/%b exp=10/11", rbusy_b, rbusy_n);
    end
    tick();
    idle();
    checks++;
    if (cnt_b !== 6'd1) begin
      failures++;
      $display("FAIL clear_cnt got=%0d exp=1", cnt_b);
    end
    mark_en = 1; mark_reg = 5'd10;
    regwr1 = 1; wreg1 = 5'd10; wdata1 = 32'h1010;
    tick();
    idle();
    rreg = {5'd9, 5'd10};
    #1;
    checks++;
    if (cnt_b !== 6'd1 || rbusy_b !== 2'b01) begin
      failures++;
      $display("FAIL set_wins cnt=%0d rbusy=%b exp 1/01", cnt_b, rbusy_b);
    end
    mark_en = 1; mark_reg = 5'd10;
    tick();
    idle();
    checks++;
    if (cnt_b !== 6'd1) begin
      failures++;
      $display("FAIL remark_cnt got=%0d exp=1", cnt_b);
    end
  endtask

  task automatic test_back_to_back();
    regwr0 = 1; wreg0 = 5'd10; wdata0 = 32'h0;
    tick();
    idle();
    checks++;
    if (cnt_b !== 6'd0) begin
      failures++;
      $display("FAIL drain_cnt got=%0d exp=0", cnt_b);
    end
    mark_en = 1; mark_reg = 5'd4; tick();
    mark_reg = 5'd6; tick();
    idle();
    checks++;
    if (cnt_b !== 6'd2) begin
      failures++;
      $display("FAIL pre_dbl got=%0d exp=2", cnt_b);
    end
    regwr0 = 1; wreg0 = 5'd4; wdata0 = 32'h4;
    regwr1 = 1; wreg1 = 5'd6; wdata1 = 32'h6;
    tick();
    idle();
    checks++;
    if (cnt_b !== 6'd0) begin
      failures++;
      $display("FAIL dbl_clear got=%0d exp=0", cnt_b);
    end
    mark_en = 1; mark_reg = 5'd4; tick();
    mark_reg = 5'd6; tick();
    idle();
    regwr0 = 1; wreg0 = 5'd4; wdata0 = 32'h44;
    regwr1 = 1; wreg1 = 5'd6; wdata1 = 32'h66;
    mark_en = 1; mark_reg = 5'd8;
    tick();
    idle();
    rreg = {5'd6, 5'd8};
    #1;
    checks++;
    if (cnt_b !== 6'd1 || rbusy_b !== 2'b01) begin
      failures++;
      $display("FAIL dbl_clear_mark cnt=%0d rbusy=%b exp 1/01", cnt_b, rbusy_b);
    end
    checks++;
    if (rdata_b[63:32] !== 32'h66) begin
      failures++;
      $display("FAIL dbl_data got=%h exp=66", rdata_b[63:32]);
    end
  endtask

  task automatic test_reset_mid();
    rreg = {5'd3, 5'd20};
    #1;
    checks++;
    if (rdata_b !== {32'h000F0000, 32'h0000000F}) begin
      failures++;
      $display("FAIL pre_mid_reset got=%h", rdata_b);
    end
    #2;
    rst = 0;
    #1;
    checks++;
    if (rdata_b !== 64'h0 || rdata_n !== 64'h0 || cnt_b !== 6'd0) begin
      failures++;
      $display("FAIL mid_reset rdata=%h/%h cnt=%0d exp 0", rdata_b, rdata_n,
               cnt_b);
    end
    regwr1 = 1; wreg1 = 5'd3; wdata1 = 32'h3333;
    tick();
    idle();
    rst = 1;
    tick();
    #1;
    checks++;
    if (rdata_b !== 64'h0 || cnt_b !== 6'd0) begin
      failures++;
      $display("FAIL post_reset rdata=%h cnt=%0d exp 0", rdata_b, cnt_b);
    end
  endtask

  initial begin
    idle();
    rreg = '0;
    rst = 1;
    #2;
    rst = 0;
    test_reset();
    test_write();
    test_collision();
    test_bypass();
    test_scoreboard();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
